// File: rtl/sha_msg_mem_responder.sv
// sha_msg_mem_responder
// Memory-side responder for the SHA-256 engine word bus. It holds a word
// array with one write port and two read ports:
//   - engine port  : mem_addr/mem_we/mem_write_data in, mem_read_data out
//                    (1-cycle read latency, read-before-write)
//   - loader port  : ld_start/ld_base/ld_byte/ld_valid/ld_last in,
//                    ld_ready/ld_done/ld_count out; packs bytes big-endian
//                    into consecutive words starting at ld_base
//   - readback port: rd_req/rd_addr in, rd_data/rd_valid out
// Addresses use only their low DEPTH_LOG2 bits, so they wrap modulo depth.
//
// Loader states:
//   state   | meaning
//   L_IDLE  | waiting for ld_start
//   L_FILL  | accepting bytes; ready whenever no word write is pending
//   L_FLUSH | last byte taken; waiting for the final word write to land
//   L_DONE  | one-cycle ld_done pulse
module sha_msg_mem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              eng_active,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_we,
   input  logic [31:0]       mem_write_data,
   output logic [31:0]       mem_read_data,
   input  logic              ld_start,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic [7:0]        ld_byte,
   input  logic              ld_valid,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              ld_done,
   output logic [31:0]       ld_count,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data,
   output logic              rd_valid
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] WIDX_ONE = 1;

   typedef enum logic [1:0] {
      L_IDLE,
      L_FILL,
      L_FLUSH,
      L_DONE
   } l_state_e;

   logic [31:0]           mem_q [0:DEPTH-1];

   l_state_e              state_q;
   logic [DEPTH_LOG2-1:0] base_q;
   logic [DEPTH_LOG2-1:0] widx_q;
   logic [1:0]            bidx_q;
   logic [31:0]           word_q;
   logic [31:0]           word_d;
   logic [31:0]           count_q;
   logic                  wr_pend_q;
   logic [DEPTH_LOG2-1:0] waddr_q;
   logic [31:0]           wdata_q;

   logic [31:0]           mem_rdata_q;
   logic [31:0]           rd_data_q;
   logic                  rd_valid_q;

   logic                  eng_wr;
   logic                  ld_ready_int;
   logic                  byte_take;
   logic [DEPTH_LOG2-1:0] eng_idx;
   logic [DEPTH_LOG2-1:0] rd_idx;

   assign eng_idx      = mem_addr[DEPTH_LOG2-1:0];
   assign rd_idx       = rd_addr[DEPTH_LOG2-1:0];
   assign eng_wr       = eng_active && mem_we;
   assign ld_ready_int = (state_q == L_FILL) && !wr_pend_q;
   assign byte_take    = ld_valid && ld_ready_int;

   // Address bits above DEPTH_LOG2 are intentionally ignored (wrap-around).
   logic unused_addr_hi;
   assign unused_addr_hi = ^{mem_addr[ADDR_W-1:DEPTH_LOG2],
                             ld_base[ADDR_W-1:DEPTH_LOG2],
                             rd_addr[ADDR_W-1:DEPTH_LOG2]};

   // Current word with the incoming byte merged at its big-endian lane.
   always_comb begin
      word_d = word_q;
      case (bidx_q)
         2'd0:    word_d[31:24] = ld_byte;
         2'd1:    word_d[23:16] = ld_byte;
         2'd2:    word_d[15:8]  = ld_byte;
         default: word_d[7:0]   = ld_byte;
      endcase
   end

   // Single write port: the engine always wins; the loader word waits.
   always_ff @(posedge clk) begin
      if (eng_wr) begin
         mem_q[eng_idx] <= mem_write_data;
      end else if (wr_pend_q) begin
         mem_q[waddr_q] <= wdata_q;
      end
   end

   // Both read ports see the array before this edge's write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_rdata_q <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         mem_rdata_q <= mem_q[eng_idx];
         rd_valid_q  <= rd_req;
         if (rd_req) begin
            rd_data_q <= mem_q[rd_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= L_IDLE;
         base_q    <= '0;
         widx_q    <= '0;
         bidx_q    <= '0;
         word_q    <= '0;
         count_q   <= '0;
         wr_pend_q <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         if (wr_pend_q && !eng_wr) begin
            wr_pend_q <= 1'b0;
         end
         case (state_q)
            L_IDLE: begin
               if (ld_start) begin
                  base_q  <= ld_base[DEPTH_LOG2-1:0];
                  widx_q  <= '0;
                  bidx_q  <= '0;
                  word_q  <= '0;
                  count_q <= '0;
                  state_q <= L_FILL;
               end
            end
            L_FILL: begin
               // byte_take implies no pending write, so setting wr_pend_q
               // here never collides with the clear above.
               if (byte_take) begin
                  count_q <= count_q + 32'd1;
                  if (bidx_q == 2'd3 || ld_last) begin
                     wr_pend_q <= 1'b1;
                     wdata_q   <= word_d;
                     waddr_q   <= base_q + widx_q;
                     widx_q    <= widx_q + WIDX_ONE;
                     bidx_q    <= '0;
                     word_q    <= '0;
                     if (ld_last) begin
                        state_q <= L_FLUSH;
                     end
                  end else begin
                     word_q <= word_d;
                     bidx_q <= bidx_q + 2'd1;
                  end
               end
            end
            L_FLUSH: begin
               if (!(wr_pend_q && eng_wr)) begin
                  state_q <= L_DONE;
               end
            end
            default: begin
               state_q <= L_IDLE;
            end
         endcase
      end
   end

   assign mem_read_data = mem_rdata_q;
   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign ld_ready      = ld_ready_int;
   assign ld_done       = (state_q == L_DONE);
   assign ld_count      = count_q;

endmodule

// File: tb/tb_sha_msg_mem_responder.sv
module tb_sha_msg_mem_responder;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        eng_active = 1'b0;
   logic [15:0] mem_addr = '0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_write_data = '0;
   logic [31:0] mem_read_data;
   logic        ld_start = 1'b0;
   logic [15:0] ld_base = '0;
   logic [7:0]  ld_byte = '0;
   logic        ld_valid = 1'b0;
   logic        ld_last = 1'b0;
   logic        ld_ready;
   logic        ld_done;
   logic [31:0] ld_count;
   logic        rd_req = 1'b0;
   logic [15:0] rd_addr = '0;
   logic [31:0] rd_data;
   logic        rd_valid;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   sha_msg_mem_responder dut (
      .clk(clk), .reset_n(reset_n), .eng_active(eng_active),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .ld_start(ld_start), .ld_base(ld_base),
      .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
      .ld_ready(ld_ready), .ld_done(ld_done), .ld_count(ld_count),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_IDLE = 0, M_FILL = 1, M_FLUSH = 2, M_DONE = 3;
   logic [31:0] mm [DEPTH];
   bit          mk [DEPTH];
   logic [7:0]  bytes [$];
   int          mode = M_IDLE;
   bit          pend = 0;
   int          pa = 0;
   logic [31:0] pd = '0;
   int          mbase = 0;
   int          widx = 0;
   logic [31:0] e_count = '0;
   logic [31:0] e_mrd = '0;
   bit          e_mrd_k = 1;
   logic [31:0] e_rdd = '0;
   bit          e_rdd_k = 1;
   logic        e_rdv = 1'b0;
   int          ma, ra;
   bit          m_engwr, m_ready, wrote_pend;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode = M_IDLE; pend = 0; e_count = '0;
         e_mrd = '0; e_mrd_k = 1; e_rdd = '0; e_rdd_k = 1; e_rdv = 1'b0;
         bytes.delete();
      end else begin
         ma = int'(mem_addr) % DEPTH;
         ra = int'(rd_addr) % DEPTH;
         m_engwr = eng_active && mem_we;
         m_ready = (mode == M_FILL) && !pend;
         e_mrd = mm[ma]; e_mrd_k = mk[ma];
         e_rdv = rd_req;
         if (rd_req) begin e_rdd = mm[ra]; e_rdd_k = mk[ra]; end
         wrote_pend = 0;
         if (m_engwr) begin
            mm[ma] = mem_write_data; mk[ma] = 1;
         end else if (pend) begin
            mm[pa] = pd; mk[pa] = 1; pend = 0; wrote_pend = 1;
         end
         case (mode)
            M_IDLE: if (ld_start) begin
               mbase = int'(ld_base) % DEPTH; widx = 0; e_count = '0;
               bytes.delete(); mode = M_FILL;
            end
            M_FILL: if (ld_valid && m_ready) begin
               e_count = e_count + 1;
               bytes.push_back(ld_byte);
               if (bytes.size() == 4 || ld_last) begin
                  pd = '0;
                  for (int i = 0; i < bytes.size(); i++)
                     pd = pd | (32'(bytes[i]) << (24 - 8 * i));
                  pa = (mbase + widx) % DEPTH;
                  widx++;
                  pend = 1;
                  bytes.delete();
                  if (ld_last) mode = M_FLUSH;
               end
            end
            M_FLUSH: if (wrote_pend) mode = M_DONE;
            default: mode = M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, (mode == M_FILL) && !pend});
      chk("ld_done", {31'b0, ld_done}, {31'b0, mode == M_DONE});
      chk("ld_count", ld_count, e_count);
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, e_rdv});
      if (e_rdd_k) chk("rd_data", rd_data, e_rdd);
      if (e_mrd_k) chk("mem_read_data", mem_read_data, e_mrd);
   end

   // ---------------- stimulus helpers (all return at a negedge) ----------------
   task automatic eng(input logic act, input logic we, input logic [15:0] a, input logic [31:0] d);
      eng_active = act; mem_we = we; mem_addr = a; mem_write_data = d;
   endtask

   task automatic start_load(input logic [15:0] b);
      ld_start = 1'b1; ld_base = b;
      @(negedge clk);
      ld_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      ld_byte = b; ld_valid = 1'b1; ld_last = last;
      while (!ld_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL send_timeout: byte %02h never accepted", b);
      end
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic wait_done(input logic [31:0] exp_count);
      int n = 0;
      while (!ld_done && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL done_timeout: ld_done never seen, expected pulse");
      end
      chk("ld_count_at_done", ld_count, exp_count);
      @(negedge clk);
   endtask

   task automatic host_read(input logic [15:0] a, input logic [31:0] exp, input string nm);
      rd_req = 1'b1; rd_addr = a;
      @(negedge clk);
      rd_req = 1'b0;
      chk(nm, rd_data, exp);
      chk({nm, "_valid"}, {31'b0, rd_valid}, 32'd1);
   endtask

   always @(negedge clk) if (ld_done) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
      chk("rst_ld_count", ld_count, 32'd0);
      chk("rst_mem_read_data", mem_read_data, 32'd0);
      chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: "abc" at 0
      done_cnt = 0;
      start_load(16'h0000);
      send_byte(8'h61, 1'b0);
      send_byte(8'h62, 1'b0);
      send_byte(8'h63, 1'b1);
      chk("t1_ready_low_after_last", {31'b0, ld_ready}, 32'd0);
      wait_done(32'd3);
      repeat (3) @(negedge clk);
      #1 chk("t1_done_pulses", done_cnt, 32'd1);
      chk("t1_count_held", ld_count, 32'd3);
      host_read(16'h0000, 32'h61626300, "t1_word0");

      // 2: five bytes at 0x10, engine readback
      @(negedge clk);
      start_load(16'h0010);
      for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
      wait_done(32'd5);
      host_read(16'h0010, 32'h01020304, "t2_word0");
      host_read(16'h0011, 32'h05000000, "t2_word1");
      eng(1'b0, 1'b0, 16'h0011, 32'h0);
      @(negedge clk);
      chk("t2_eng_read", mem_read_data, 32'h05000000);

      // 3: engine write collides with loader word for 0x21
      eng(1'b1, 1'b1, 16'h0021, 32'hAAAAAAAA);
      @(negedge clk);
      eng(1'b1, 1'b1, 16'h0020, 32'hDEADBEEF);
      start_load(16'h0021);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);
      repeat (3) @(negedge clk);
      chk("t3_ready_blocked", {31'b0, ld_ready}, 32'd0);
      host_read(16'h0021, 32'hAAAAAAAA, "t3_blocked_word");
      eng(1'b0, 1'b0, 16'h0020, 32'h0);
      wait_done(32'd4);
      host_read(16'h0021, 32'h11223344, "t3_loader_word");
      host_read(16'h0020, 32'hDEADBEEF, "t3_engine_word");

      // 4: mem_we ignored when inactive; read-before-write
      eng(1'b1, 1'b1, 16'h0030, 32'h11111111);
      @(negedge clk);
      eng(1'b0, 1'b1, 16'h0030, 32'h99999999);
      repeat (2) @(negedge clk);
      chk("t4_inactive_we", mem_read_data, 32'h11111111);
      eng(1'b1, 1'b1, 16'h0030, 32'h22222222);
      @(negedge clk);
      chk("t4_rbw_old", mem_read_data, 32'h11111111);
      eng(1'b0, 1'b0, 16'h0030, 32'h0);
      @(negedge clk);
      chk("t4_rbw_new", mem_read_data, 32'h22222222);

      // 5: wrap at top of array
      start_load(16'h03FF);
      for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), i == 7);
      wait_done(32'd8);
      host_read(16'h03FF, 32'h10111213, "t5_word_top");
      host_read(16'h0400, 32'h14151617, "t5_word_wrap");
      @(negedge clk);
      chk("t5_rd_valid_drop", {31'b0, rd_valid}, 32'd0);

      // 6: reset mid-load
      eng(1'b1, 1'b1, 16'h0041, 32'hCAFEF00D);
      @(negedge clk);
      eng(1'b0, 1'b0, 16'h0000, 32'h0);
      start_load(16'h0040);
      for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b0);
      chk("t6_count_before_reset", ld_count, 32'd6);
      #2 reset_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_count", ld_count, 32'd0);
      chk("t6_rst_ready", {31'b0, ld_ready}, 32'd0);
      chk("t6_rst_mrd", mem_read_data, 32'd0);
      #2 reset_n = 1'b1;
      @(negedge clk);
      host_read(16'h0040, 32'hA0A1A2A3, "t6_first_word");
      host_read(16'h0041, 32'hCAFEF00D, "t6_untouched_word");
      start_load(16'h0050);
      send_byte(8'hB0, 1'b0);
      send_byte(8'hB1, 1'b1);
      wait_done(32'd2);
      host_read(16'h0050, 32'hB0B10000, "t6_reload_word");

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
